// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, req/ack instruction fetch and IF/ID register with stall, hold and redirect handling
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ifin_stall,
    input  logic        ifin_redirect,
    input  logic [31:0] ifin_redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifout_id_inst_orig,
    output logic [31:0] ifout_id_pc,
    output logic        ifout_id_valid
);
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic        hold_valid;
    // DROP keeps presenting the abandoned address so the memory sees a stable request
    assign imem_req  = state != IDLE;
    assign imem_addr = state == DROP ? drop_addr : pc;
    // fetch sequencing, hold buffer and IF/ID register; redirect outranks stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            pc                 <= RESET_PC;
            drop_addr          <= 32'h0;
            hold_inst          <= 32'h0;
            hold_pc            <= 32'h0;
            hold_valid         <= 1'b0;
            ifout_id_inst_orig <= NOP_INST;
            ifout_id_pc        <= 32'h0;
            ifout_id_valid     <= 1'b0;
        end else if (ifin_redirect) begin
            pc                 <= ifin_redirect_pc;
            hold_valid         <= 1'b0;
            ifout_id_inst_orig <= NOP_INST;
            ifout_id_valid     <= 1'b0;
            state              <= state != IDLE && !imem_ack ? DROP : REQ;
            if (state == REQ && !imem_ack) drop_addr <= pc;
        end else begin
            case (state)
                IDLE: begin
                    if (!hold_valid) state <= REQ;
                    else if (!ifin_stall) begin
                        ifout_id_inst_orig <= hold_inst;
                        ifout_id_pc        <= hold_pc;
                        ifout_id_valid     <= 1'b1;
                        hold_valid         <= 1'b0;
                        state              <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (ifin_stall) begin
                            hold_inst  <= imem_rdata;
                            hold_pc    <= pc;
                            hold_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            ifout_id_inst_orig <= imem_rdata;
                            ifout_id_pc        <= pc;
                            ifout_id_valid     <= 1'b1;
                        end
                    end else if (!ifin_stall) begin
                        ifout_id_inst_orig <= NOP_INST;
                        ifout_id_valid     <= 1'b0;
                    end
                end
                DROP: if (imem_ack) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
